// File: rtl/refresh_issuer_pkg.sv
// refresh_issuer_pkg
// Definitions shared by the refresh issuer and the command arbiter:
// command-bus opcode encoding, the issuer state enum and the default
// DRAM timing constants used as parameter defaults.
package refresh_issuer_pkg;

  // Command-bus opcodes seen by the arbiter
  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_PREA = 2'd1;
  localparam logic [1:0] CMD_REF  = 2'd2;

  // Default timing, in controller clock cycles
  localparam int T_RP_DEFAULT  = 18;
  localparam int T_RFC_DEFAULT = 350;
  localparam int GRACE_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEFER     = 3'd1,
    ST_HOLD      = 3'd2,
    ST_PREA      = 3'd3,
    ST_WAIT_RP   = 3'd4,
    ST_REF       = 3'd5,
    ST_WAIT_DONE = 3'd6,
    ST_COOLDOWN  = 3'd7
  } state_t;

endpackage

// File: rtl/refresh_issuer.sv
// refresh_issuer
// Turns the refresh manager's refresh_needed level into a complete
// all-bank refresh: optionally defers while host traffic is busy, freezes
// the bank machines, issues PREA (only if a row is open) then REF to the
// command arbiter, pulses refresh to start the manager's tRFC count and
// releases the banks once refresh_done returns (or a watchdog expires).
//
// Ports
//   sys_clk, sys_rst   : clock, asynchronous active-high reset
//   refresh_needed     : request level from the refresh manager
//   refresh_done       : completion from the refresh manager (>=1 cycle)
//   traffic_busy       : host requests pending, allows deferral
//   bank_open[15:0]    : per {bank_group, bank} open-row flags
//   hold_ack           : bank machines idle and frozen
//   cmd_ready          : arbiter accepts the command this cycle
//   refresh            : one-cycle start pulse to the refresh manager
//   bank_group, bank   : refresh target, always 0 (all-bank refresh)
//   hold_req           : freeze new ACT/RD/WR in the bank machines
//   cmd_valid, cmd_op  : command to the arbiter (NOP/PREA/REF)
//   busy               : sequence in progress (state != IDLE)
//   timeout_err        : sticky, refresh_done never came back
module refresh_issuer
  import refresh_issuer_pkg::*;
#(
  parameter int T_RP  = T_RP_DEFAULT,
  parameter int GRACE = GRACE_DEFAULT,
  parameter int T_RFC = T_RFC_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        refresh_needed,
  input  logic        refresh_done,
  input  logic        traffic_busy,
  input  logic [15:0] bank_open,
  input  logic        hold_ack,
  input  logic        cmd_ready,
  output logic        refresh,
  output logic [1:0]  bank_group,
  output logic [1:0]  bank,
  output logic        hold_req,
  output logic        cmd_valid,
  output logic [1:0]  cmd_op,
  output logic        busy,
  output logic        timeout_err
);

  // One shared counter, wide enough for the longest wait and never below 10 bits
  localparam int CNT_REQ = $clog2(2 * T_RFC + GRACE + T_RP + 1);
  localparam int CNT_W   = (CNT_REQ > 10) ? CNT_REQ : 10;

  // Counter is 0 in the first cycle of a state, so "N cycles" ends at N-1
  localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE - 1);
  localparam logic [CNT_W-1:0] RP_LAST    = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LAST   = CNT_W'(2 * T_RFC - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  logic             w_refresh;
  logic             w_timeout;
  logic             w_hold_req;
  logic             w_cmd_valid;
  logic [1:0]       w_cmd_op;

  logic             r_refresh;
  logic             r_hold_req;
  logic             r_cmd_valid;
  logic [1:0]       r_cmd_op;
  logic             r_busy;
  logic             r_timeout_err;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_refresh   = 1'b0;
    w_timeout   = 1'b0;
    w_hold_req  = 1'b0;
    w_cmd_valid = 1'b0;
    w_cmd_op    = CMD_NOP;

    case (r_state)
      ST_IDLE: begin
        if (refresh_needed)
          w_next = traffic_busy ? ST_DEFER : ST_HOLD;
      end
      // Manager withdrawing the request before any command is issued aborts
      ST_DEFER: begin
        if (!refresh_needed)
          w_next = ST_IDLE;
        else if (!traffic_busy || (r_cnt == GRACE_LAST))
          w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!refresh_needed)
          w_next = ST_IDLE;
        else if (hold_ack)
          w_next = (|bank_open) ? ST_PREA : ST_REF;
      end
      ST_PREA: begin
        if (cmd_ready)
          w_next = ST_WAIT_RP;
      end
      ST_WAIT_RP: begin
        if (r_cnt == RP_LAST)
          w_next = ST_REF;
      end
      ST_REF: begin
        if (cmd_ready) begin
          w_next    = ST_WAIT_DONE;
          w_refresh = 1'b1;
        end
      end
      // A done arriving in the last watchdog cycle still counts as success
      ST_WAIT_DONE: begin
        if (refresh_done) begin
          w_next = ST_COOLDOWN;
        end else if (r_cnt == RFC_LAST) begin
          w_next    = ST_COOLDOWN;
          w_timeout = 1'b1;
        end
      end
      // Wait for the manager to drop both lines so a stale level cannot retrigger
      ST_COOLDOWN: begin
        if (!refresh_needed && !refresh_done)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and then registered
    case (w_next)
      ST_HOLD, ST_WAIT_RP, ST_WAIT_DONE: w_hold_req = 1'b1;
      ST_PREA: begin
        w_hold_req  = 1'b1;
        w_cmd_valid = 1'b1;
        w_cmd_op    = CMD_PREA;
      end
      ST_REF: begin
        w_hold_req  = 1'b1;
        w_cmd_valid = 1'b1;
        w_cmd_op    = CMD_REF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_refresh     <= 1'b0;
      r_hold_req    <= 1'b0;
      r_cmd_valid   <= 1'b0;
      r_cmd_op      <= CMD_NOP;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_refresh     <= w_refresh;
      r_hold_req    <= w_hold_req;
      r_cmd_valid   <= w_cmd_valid;
      r_cmd_op      <= w_cmd_op;
      r_busy        <= (w_next != ST_IDLE);
      r_timeout_err <= r_timeout_err | w_timeout;
    end
  end

  assign refresh     = r_refresh;
  assign hold_req    = r_hold_req;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_op      = r_cmd_op;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign bank_group  = 2'b00;
  assign bank        = 2'b00;

endmodule

// File: tb/tb_refresh_issuer.sv
// tb_refresh_issuer
// Directed bench for refresh_issuer with default timing
// (T_RP=18, GRACE=64, T_RFC=350). Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_refresh_issuer;

  logic        sys_clk;
  logic        sys_rst;
  logic        refresh_needed;
  logic        refresh_done;
  logic        traffic_busy;
  logic [15:0] bank_open;
  logic        hold_ack;
  logic        cmd_ready;
  logic        refresh;
  logic [1:0]  bank_group;
  logic [1:0]  bank;
  logic        hold_req;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  refresh_issuer dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .refresh_needed(refresh_needed),
    .refresh_done  (refresh_done),
    .traffic_busy  (traffic_busy),
    .bank_open     (bank_open),
    .hold_ack      (hold_ack),
    .cmd_ready     (cmd_ready),
    .refresh       (refresh),
    .bank_group    (bank_group),
    .bank          (bank),
    .hold_req      (hold_req),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Let a started sequence run to the refresh pulse, complete it, return to IDLE
  task automatic finish_seq(input string tag);
    int n;
    n = 0;
    while (!refresh && n < 60) begin
      tick();
      n++;
    end
    chk1({tag, "_refresh_seen"}, refresh, 1'b1);
    refresh_needed = 1'b0;
    traffic_busy   = 1'b0;
    refresh_done   = 1'b1;
    tick();
    refresh_done   = 1'b0;
    tick();
    chk1({tag, "_back_idle"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    int pulses;
    int first;
    logic stable;

    sys_rst        = 1'b1;
    refresh_needed = 1'b0;
    refresh_done   = 1'b0;
    traffic_busy   = 1'b0;
    bank_open      = 16'h0000;
    hold_ack       = 1'b0;
    cmd_ready      = 1'b0;
    tick();
    tick();

    // Reset values
    chk1("rst_refresh", refresh, 1'b0);
    chk1("rst_hold_req", hold_req, 1'b0);
    chk1("rst_cmd_valid", cmd_valid, 1'b0);
    chkn("rst_cmd_op", int'(cmd_op), 0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    chkn("rst_bank_group", int'(bank_group), 0);
    chkn("rst_bank", int'(bank), 0);
    sys_rst = 1'b0;
    tick();
    chk1("idle_busy", busy, 1'b0);

    // Best case: no traffic, banks closed, ack/ready tied high
    hold_ack       = 1'b1;
    cmd_ready      = 1'b1;
    refresh_needed = 1'b1;
    tick();
    chk1("t1_hold_c1", hold_req, 1'b1);
    chk1("t1_valid_c1", cmd_valid, 1'b0);
    tick();
    chk1("t1_valid_c2", cmd_valid, 1'b1);
    chkn("t1_op_c2", int'(cmd_op), 2);
    chk1("t1_refresh_c2", refresh, 1'b0);
    tick();
    chk1("t1_refresh_c3", refresh, 1'b1);
    chk1("t1_valid_c3", cmd_valid, 1'b0);
    tick();
    chk1("t1_refresh_c4", refresh, 1'b0);
    chk1("t1_hold_wait", hold_req, 1'b1);
    repeat (5) tick();
    refresh_done = 1'b1;
    tick();
    refresh_done = 1'b0;
    chk1("t1_hold_cool", hold_req, 1'b0);
    chk1("t1_busy_cool", busy, 1'b1);
    repeat (4) tick();
    chk1("t1_no_retrigger", hold_req | cmd_valid, 1'b0);
    chk1("t1_still_cool", busy, 1'b1);
    refresh_needed = 1'b0;
    tick();
    chk1("t1_idle", busy, 1'b0);

    // Open bank: PREA first, REF valid 19 cycles after the PREA accept
    bank_open      = 16'h0004;
    cmd_ready      = 1'b0;
    refresh_needed = 1'b1;
    tick();
    tick();
    chk1("t2_prea_valid", cmd_valid, 1'b1);
    chkn("t2_prea_op", int'(cmd_op), 1);
    tick();
    chk1("t2_prea_valid_hold", cmd_valid, 1'b1);
    chkn("t2_prea_op_hold", int'(cmd_op), 1);
    cmd_ready = 1'b1;
    tick();
    n = 1;
    chk1("t2_rp_valid_low", cmd_valid, 1'b0);
    chk1("t2_rp_hold", hold_req, 1'b1);
    while (!cmd_valid && n < 40) begin
      tick();
      n++;
    end
    chkn("t2_ref_delay", n, 19);
    chkn("t2_ref_op", int'(cmd_op), 2);
    tick();
    chk1("t2_refresh", refresh, 1'b1);
    refresh_needed = 1'b0;
    bank_open      = 16'h0000;
    tick();
    chk1("t2_hold_after_drop", hold_req, 1'b1);
    refresh_done = 1'b1;
    tick();
    refresh_done = 1'b0;
    chk1("t2_hold_cool", hold_req, 1'b0);
    tick();
    chk1("t2_idle", busy, 1'b0);

    // Traffic held busy: full 64-cycle deferral, HOLD at cycle 65
    traffic_busy   = 1'b1;
    refresh_needed = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!hold_req && n < 200);
    chkn("t3_defer_full", n, 65);
    finish_seq("t3");

    // Traffic drops at cycle 10: HOLD at cycle 11
    traffic_busy   = 1'b1;
    refresh_needed = 1'b1;
    repeat (10) tick();
    chk1("t3b_c10_hold", hold_req, 1'b0);
    chk1("t3b_c10_busy", busy, 1'b1);
    traffic_busy = 1'b0;
    tick();
    chk1("t3b_c11_hold", hold_req, 1'b1);
    finish_seq("t3b");

    // Abort in HOLD: request withdrawn before hold_ack
    hold_ack       = 1'b0;
    refresh_needed = 1'b1;
    tick();
    chk1("ab_hold", hold_req, 1'b1);
    refresh_needed = 1'b0;
    tick();
    chk1("ab_hold_drop", hold_req, 1'b0);
    chk1("ab_busy", busy, 1'b0);
    repeat (3) tick();
    chk1("ab_no_cmd", cmd_valid | refresh, 1'b0);
    hold_ack = 1'b1;

    // REF back-pressured for 5 cycles
    cmd_ready      = 1'b0;
    refresh_needed = 1'b1;
    stable = 1'b1;
    pulses = 0;
    first  = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c >= 2 && c <= 7 && !(cmd_valid === 1'b1 && cmd_op === 2'd2))
        stable = 1'b0;
      if (c == 7)
        cmd_ready = 1'b1;
      if (refresh === 1'b1) begin
        pulses++;
        if (first < 0)
          first = c;
      end
    end
    chk1("t4_ref_stable", stable, 1'b1);
    chkn("t4_pulse_count", pulses, 1);
    chkn("t4_pulse_cycle", first, 8);
    refresh_needed = 1'b0;
    refresh_done   = 1'b1;
    tick();
    refresh_done = 1'b0;
    tick();
    chk1("t4_idle", busy, 1'b0);

    // refresh_done never returns: watchdog after 700 cycles in WAIT_DONE
    refresh_needed = 1'b1;
    repeat (3) tick();
    chk1("t5_refresh", refresh, 1'b1);
    repeat (699) tick();
    chk1("t5_c702_timeout", timeout_err, 1'b0);
    chk1("t5_c702_hold", hold_req, 1'b1);
    tick();
    chk1("t5_c703_timeout", timeout_err, 1'b1);
    chk1("t5_c703_hold", hold_req, 1'b0);
    chk1("t5_c703_busy", busy, 1'b1);
    refresh_needed = 1'b0;
    tick();
    chk1("t5_idle", busy, 1'b0);
    repeat (5) tick();
    chk1("t5_sticky", timeout_err, 1'b1);

    // Asynchronous reset in WAIT_RP, then restart from IDLE
    bank_open      = 16'h0004;
    refresh_needed = 1'b1;
    repeat (4) tick();
    chk1("t6_rp_hold", hold_req, 1'b1);
    chk1("t6_rp_valid", cmd_valid, 1'b0);
    sys_rst = 1'b1;
    #2;
    chk1("t6_async_hold", hold_req, 1'b0);
    chk1("t6_async_busy", busy, 1'b0);
    chk1("t6_async_timeout", timeout_err, 1'b0);
    chk1("t6_async_valid", cmd_valid, 1'b0);
    tick();
    sys_rst = 1'b0;
    tick();
    chk1("t6_restart_hold", hold_req, 1'b1);
    chk1("t6_restart_valid", cmd_valid, 1'b0);
    tick();
    chk1("t6_restart_prea", cmd_valid, 1'b1);
    chkn("t6_restart_op", int'(cmd_op), 1);
    bank_open = 16'h0000;
    finish_seq("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
